// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: output-mode constants and a safe ceil-log2
// used to size pointers in the single- and dual-clock FIFOs.
package fifo_pkg;

    localparam logic FIFO_MODE_STD  = 1'b0;
    localparam logic FIFO_MODE_FWFT = 1'b1;

    // ceil(log2(value)), never below 1 so a depth-2 FIFO still gets an address bit
    function automatic int clog2s(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read/status bundle of the single-clock FIFO. The FIFO is the slave;
// whoever produces and consumes words is the master.
interface sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) ();

    localparam int PTR_WIDTH = clog2s(FIFO_DEPTH);

    logic                  flush_i;
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  full_o;
    logic                  afull_o;
    logic                  rd_en_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  empty_o;
    logic                  aempty_o;
    logic [PTR_WIDTH:0]    cnt_o;
    logic                  ovf_o;
    logic                  udf_o;
    logic                  err_clr_i;

    modport master (
        output flush_i, wr_en_i, wr_data_i, rd_en_i, err_clr_i,
        input  full_o, afull_o, rd_data_o, empty_o, aempty_o, cnt_o, ovf_o, udf_o
    );

    modport slave (
        input  flush_i, wr_en_i, wr_data_i, rd_en_i, err_clr_i,
        output full_o, afull_o, rd_data_o, empty_o, aempty_o, cnt_o, ovf_o, udf_o
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port with
// enable. The array is not reset so it maps onto block RAM.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (we_i) r_mem[waddr_i] <= wdata_i;
    end

    // Output register holds its value while re_i is low; it doubles as the FIFO read-data register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)   r_rdata <= '0;
        else if (re_i) r_rdata <= r_mem[raddr_i];
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer/count/flag logic around sync_fifo_ram, with
// standard or first-word-fall-through output and sticky error flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int   DATA_WIDTH     = 8,
    parameter int   FIFO_DEPTH     = 16,
    parameter logic DATA_FLOAT_OUT = FIFO_MODE_STD,
    parameter int   AFULL_TH       = FIFO_DEPTH - 2,
    parameter int   AEMPTY_TH      = 2
) (
    input logic        clk_i,
    input logic        rstn_i,
    sync_fifo_if.slave bus
);

    localparam int                 PTR_WIDTH  = clog2s(FIFO_DEPTH);
    localparam logic [PTR_WIDTH:0] CNT_ONE    = 1;
    localparam logic [PTR_WIDTH:0] DEPTH_CNT  = FIFO_DEPTH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AFULL_CNT  = AFULL_TH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AEMPTY_CNT = AEMPTY_TH[PTR_WIDTH:0];

    logic [PTR_WIDTH:0]    r_wptr, r_rptr, r_cnt;
    logic                  r_valid, r_full, r_afull, r_empty, r_aempty, r_ovf, r_udf;
    logic [PTR_WIDTH:0]    w_cnt_nxt;
    logic                  w_wr_acc, w_rd_acc, w_ram_re, w_ram_nempty, w_valid_nxt, w_empty_nxt;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_wr_acc     = bus.wr_en_i && !r_full  && !bus.flush_i;
    assign w_rd_acc     = bus.rd_en_i && !r_empty && !bus.flush_i;
    assign w_ram_nempty = (r_wptr != r_rptr);

    // In FWFT the read pointer tracks the RAM prefetch, not the consumer pop.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_wr_acc && !w_rd_acc)      w_cnt_nxt = r_cnt + CNT_ONE;
        else if (!w_wr_acc && w_rd_acc) w_cnt_nxt = r_cnt - CNT_ONE;

        if (DATA_FLOAT_OUT == FIFO_MODE_FWFT) begin
            w_ram_re    = w_ram_nempty && (!r_valid || w_rd_acc) && !bus.flush_i;
            w_valid_nxt = w_ram_re || (r_valid && !w_rd_acc);
            w_empty_nxt = !w_valid_nxt;
        end else begin
            w_ram_re    = w_rd_acc;
            w_valid_nxt = 1'b0;
            w_empty_nxt = (w_cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
        end else if (bus.flush_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + CNT_ONE;
            if (w_ram_re) r_rptr <= r_rptr + CNT_ONE;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_valid_nxt;
            r_full   <= (w_cnt_nxt == DEPTH_CNT);
            r_afull  <= (w_cnt_nxt >= AFULL_CNT);
            r_empty  <= w_empty_nxt;
            r_aempty <= (w_cnt_nxt <= AEMPTY_CNT);
        end
    end

    // Sticky errors: a new violation in the clearing cycle keeps the flag set.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (bus.wr_en_i && r_full)  r_ovf <= 1'b1;
            else if (bus.err_clr_i)     r_ovf <= 1'b0;
            if (bus.rd_en_i && r_empty) r_udf <= 1'b1;
            else if (bus.err_clr_i)     r_udf <= 1'b0;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .we_i    (w_wr_acc),
        .waddr_i (r_wptr[PTR_WIDTH-1:0]),
        .wdata_i (bus.wr_data_i),
        .re_i    (w_ram_re),
        .raddr_i (r_rptr[PTR_WIDTH-1:0]),
        .rdata_o (w_ram_rdata)
    );

    assign bus.full_o    = r_full;
    assign bus.afull_o   = r_afull;
    assign bus.empty_o   = r_empty;
    assign bus.aempty_o  = r_aempty;
    assign bus.cnt_o     = r_cnt;
    assign bus.ovf_o     = r_ovf;
    assign bus.udf_o     = r_udf;
    assign bus.rd_data_o = w_ram_rdata;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-mode and an FWFT instance share one stimulus
// stream and are checked against queue-based reference models.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] wr_data = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bs ();
    sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bf ();

    assign bs.flush_i = flush;   assign bf.flush_i = flush;
    assign bs.wr_en_i = wr_en;   assign bf.wr_en_i = wr_en;
    assign bs.wr_data_i = wr_data; assign bf.wr_data_i = wr_data;
    assign bs.rd_en_i = rd_en;   assign bf.rd_en_i = rd_en;
    assign bs.err_clr_i = err_clr; assign bf.err_clr_i = err_clr;

    sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DATA_FLOAT_OUT(FIFO_MODE_STD),
                .AFULL_TH(AF), .AEMPTY_TH(AE)) u_std (.clk_i(clk), .rstn_i(rst_n), .bus(bs));
    sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DATA_FLOAT_OUT(FIFO_MODE_FWFT),
                .AFULL_TH(AF), .AEMPTY_TH(AE)) u_fwft (.clk_i(clk), .rstn_i(rst_n), .bus(bf));

    // Reference models: every unpopped word lives in a queue; the FWFT model
    // additionally tracks whether the head has been loaded to the output.
    logic [DW-1:0] m_q_s[$];
    logic [DW-1:0] m_q_f[$];
    logic [DW-1:0] m_rd_s;
    logic m_shown, m_ovf_s, m_udf_s, m_ovf_f, m_udf_f;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q_s.delete(); m_q_f.delete();
            m_rd_s = '0; m_shown = 1'b0;
            m_ovf_s = 1'b0; m_udf_s = 1'b0; m_ovf_f = 1'b0; m_udf_f = 1'b0;
        end else begin
            if (wr_en && m_q_s.size() == DEPTH) m_ovf_s = 1'b1; else if (err_clr) m_ovf_s = 1'b0;
            if (rd_en && m_q_s.size() == 0)     m_udf_s = 1'b1; else if (err_clr) m_udf_s = 1'b0;
            if (wr_en && m_q_f.size() == DEPTH) m_ovf_f = 1'b1; else if (err_clr) m_ovf_f = 1'b0;
            if (rd_en && !m_shown)              m_udf_f = 1'b1; else if (err_clr) m_udf_f = 1'b0;
            if (flush) begin
                m_q_s.delete(); m_q_f.delete(); m_shown = 1'b0;
            end else begin
                automatic bit s_full = (m_q_s.size() == DEPTH);
                automatic bit f_full = (m_q_f.size() == DEPTH);
                if (rd_en && m_q_s.size() != 0) m_rd_s = m_q_s.pop_front();
                if (wr_en && !s_full) m_q_s.push_back(wr_data);
                if (rd_en && m_shown) begin void'(m_q_f.pop_front()); m_shown = 1'b0; end
                if (!m_shown && m_q_f.size() > 0) m_shown = 1'b1;
                if (wr_en && !f_full) m_q_f.push_back(wr_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic apply_reset();
        idle(); rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    endtask

    task automatic test_reset();
        logic [18:0] exp_v;
        idle(); wr_data = '0;
        rst_n = 1'b0; tick(); tick();
        exp_v = {6'b001100, 5'd0, 8'd0};
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({bs.full_o, bs.afull_o, bs.empty_o, bs.aempty_o, bs.ovf_o, bs.udf_o, bs.cnt_o, bs.rd_data_o} !== exp_v) begin
                n_err++;
                $display("FAIL reset_std phase=%0d got=%h exp=%h", k,
                         {bs.full_o, bs.afull_o, bs.empty_o, bs.aempty_o, bs.ovf_o, bs.udf_o, bs.cnt_o, bs.rd_data_o}, exp_v);
            end
            n_vec++;
            if ({bf.full_o, bf.afull_o, bf.empty_o, bf.aempty_o, bf.ovf_o, bf.udf_o, bf.cnt_o, bf.rd_data_o} !== exp_v) begin
                n_err++;
                $display("FAIL reset_fwft phase=%0d got=%h exp=%h", k,
                         {bf.full_o, bf.afull_o, bf.empty_o, bf.aempty_o, bf.ovf_o, bf.udf_o, bf.cnt_o, bf.rd_data_o}, exp_v);
            end
            rst_n = 1'b1; tick();
        end
    endtask

    task automatic test_fill();
        logic [7:0] exp_s, exp_f;
        for (int i = 1; i <= DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); tick();
            exp_s = {i == DEPTH, i >= AF, 1'b0, 5'(i)};
            exp_f = {i == DEPTH, i >= AF, i < 2, 5'(i)};
            n_vec++;
            if ({bs.full_o, bs.afull_o, bs.empty_o, bs.cnt_o} !== exp_s) begin
                n_err++; $display("FAIL fill_std n=%0d got=%h exp=%h", i, {bs.full_o, bs.afull_o, bs.empty_o, bs.cnt_o}, exp_s);
            end
            n_vec++;
            if ({bf.full_o, bf.afull_o, bf.empty_o, bf.cnt_o} !== exp_f) begin
                n_err++; $display("FAIL fill_fwft n=%0d got=%h exp=%h", i, {bf.full_o, bf.afull_o, bf.empty_o, bf.cnt_o}, exp_f);
            end
        end
        wr_data = 8'hFF; tick(); wr_en = 1'b0;
        n_vec++;
        if ({bs.ovf_o, bs.full_o, bs.cnt_o, bf.ovf_o, bf.full_o, bf.cnt_o} !== {2'b11, 5'd16, 2'b11, 5'd16}) begin
            n_err++; $display("FAIL overflow got std ovf=%b cnt=%0d fwft ovf=%b cnt=%0d exp ovf=1 cnt=16",
                              bs.ovf_o, bs.cnt_o, bf.ovf_o, bf.cnt_o);
        end
    endtask

    task automatic test_drain();
        logic [14:0] exp_s;
        logic [5:0]  exp_f;
        rd_en = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            n_vec++;
            if (bf.rd_data_o !== 8'(i)) begin
                n_err++; $display("FAIL drain_fwft_head n=%0d got=%h exp=%h", i, bf.rd_data_o, 8'(i));
            end
            tick();
            exp_s = {8'(i), 5'(DEPTH - i), i == DEPTH, (DEPTH - i) <= AE};
            exp_f = {5'(DEPTH - i), i == DEPTH};
            n_vec++;
            if ({bs.rd_data_o, bs.cnt_o, bs.empty_o, bs.aempty_o} !== exp_s) begin
                n_err++; $display("FAIL drain_std n=%0d got=%h exp=%h", i, {bs.rd_data_o, bs.cnt_o, bs.empty_o, bs.aempty_o}, exp_s);
            end
            n_vec++;
            if ({bf.cnt_o, bf.empty_o} !== exp_f) begin
                n_err++; $display("FAIL drain_fwft n=%0d got=%h exp=%h", i, {bf.cnt_o, bf.empty_o}, exp_f);
            end
        end
        tick(); rd_en = 1'b0;
        n_vec++;
        if ({bs.udf_o, bf.udf_o, bs.rd_data_o} !== {2'b11, 8'h10}) begin
            n_err++; $display("FAIL underflow got udf_std=%b udf_fwft=%b rd=%h exp 1 1 10", bs.udf_o, bf.udf_o, bs.rd_data_o);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_vec++;
        if ({bs.ovf_o, bs.udf_o, bf.ovf_o, bf.udf_o} !== 4'b0000) begin
            n_err++; $display("FAIL err_clr got %b exp 0000", {bs.ovf_o, bs.udf_o, bf.ovf_o, bf.udf_o});
        end
    endtask

    task automatic test_fwft_single();
        apply_reset();
        wr_en = 1'b1; wr_data = 8'hA5; tick(); wr_en = 1'b0;
        n_vec++;
        if ({bf.empty_o, bf.cnt_o, bs.empty_o} !== {1'b1, 5'd1, 1'b0}) begin
            n_err++; $display("FAIL fwft_lat1 got empty=%b cnt=%0d std_empty=%b exp 1 1 0", bf.empty_o, bf.cnt_o, bs.empty_o);
        end
        tick();
        n_vec++;
        if ({bf.empty_o, bf.rd_data_o} !== {1'b0, 8'hA5}) begin
            n_err++; $display("FAIL fwft_lat2 got empty=%b data=%h exp 0 a5", bf.empty_o, bf.rd_data_o);
        end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_vec++;
        if ({bf.empty_o, bf.cnt_o, bf.udf_o, bs.rd_data_o, bs.cnt_o} !== {1'b1, 5'd0, 1'b0, 8'hA5, 5'd0}) begin
            n_err++; $display("FAIL fwft_pop got empty=%b cnt=%0d udf=%b std_rd=%h std_cnt=%0d exp 1 0 0 a5 0",
                              bf.empty_o, bf.cnt_o, bf.udf_o, bs.rd_data_o, bs.cnt_o);
        end
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] exp_rd;
        int cnt;
        apply_reset();
        wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = 8'($urandom); exp_q.push_back(wr_data); tick();
        end
        cnt = DEPTH; exp_rd = '0;
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 8'($urandom);
            if (cnt > 0) begin exp_rd = exp_q.pop_front(); cnt--; end
            if (cnt + 1 < DEPTH + 1 && !(i == 0)) begin exp_q.push_back(wr_data); cnt++; end
            tick();
            n_vec++;
            if ({bs.rd_data_o, bs.cnt_o, bs.full_o} !== {exp_rd, 5'(cnt), cnt == DEPTH}) begin
                n_err++; $display("FAIL full_rw_std cyc=%0d got rd=%h cnt=%0d full=%b exp rd=%h cnt=%0d", i,
                                  bs.rd_data_o, bs.cnt_o, bs.full_o, exp_rd, cnt);
            end
            n_vec++;
            if ({bf.rd_data_o, bf.cnt_o, bf.full_o} !== {exp_q[0], 5'(cnt), cnt == DEPTH}) begin
                n_err++; $display("FAIL full_rw_fwft cyc=%0d got rd=%h cnt=%0d full=%b exp rd=%h cnt=%0d", i,
                                  bf.rd_data_o, bf.cnt_o, bf.full_o, exp_q[0], cnt);
            end
        end
        idle();
    endtask

    task automatic test_flush();
        apply_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin wr_data = 8'(8'h30 + i); tick(); end
        wr_en = 1'b0; rd_en = 1'b1; tick(); rd_en = 1'b0; tick();
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; tick(); idle();
        n_vec++;
        if ({bs.full_o, bs.afull_o, bs.empty_o, bs.aempty_o, bs.ovf_o, bs.cnt_o, bs.rd_data_o} !== {5'b00110, 5'd0, 8'h30}) begin
            n_err++; $display("FAIL flush_std got %h exp %h",
                              {bs.full_o, bs.afull_o, bs.empty_o, bs.aempty_o, bs.ovf_o, bs.cnt_o, bs.rd_data_o}, {5'b00110, 5'd0, 8'h30});
        end
        n_vec++;
        if ({bf.full_o, bf.afull_o, bf.empty_o, bf.aempty_o, bf.ovf_o, bf.cnt_o} !== {5'b00110, 5'd0}) begin
            n_err++; $display("FAIL flush_fwft got %h exp %h",
                              {bf.full_o, bf.afull_o, bf.empty_o, bf.aempty_o, bf.ovf_o, bf.cnt_o}, {5'b00110, 5'd0});
        end
        wr_en = 1'b1; wr_data = 8'h77; tick(); wr_en = 1'b0; tick();
        n_vec++;
        if ({bf.rd_data_o, bf.cnt_o, bs.cnt_o} !== {8'h77, 5'd1, 5'd1}) begin
            n_err++; $display("FAIL flush_after_fwft got rd=%h cnt=%0d std_cnt=%0d exp 77 1 1", bf.rd_data_o, bf.cnt_o, bs.cnt_o);
        end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_vec++;
        if (bs.rd_data_o !== 8'h77) begin
            n_err++; $display("FAIL flush_after_std got rd=%h exp 77", bs.rd_data_o);
        end
    endtask

    task automatic test_random();
        logic [18:0] exp_s;
        logic [10:0] exp_f;
        int wp, rp;
        for (int ph = 0; ph < 4; ph++) begin
            wp = (ph % 2 == 0) ? 80 : 25;
            rp = (ph % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 250; i++) begin
                wr_en = ($urandom_range(0, 99) < wp);
                rd_en = ($urandom_range(0, 99) < rp);
                err_clr = ($urandom_range(0, 39) == 0);
                wr_data = 8'($urandom);
                tick();
                exp_s = {m_q_s.size() == DEPTH, m_q_s.size() >= AF, m_q_s.size() == 0, m_q_s.size() <= AE,
                         m_ovf_s, m_udf_s, 5'(m_q_s.size()), m_rd_s};
                exp_f = {m_q_f.size() == DEPTH, m_q_f.size() >= AF, !m_shown, m_q_f.size() <= AE,
                         m_ovf_f, m_udf_f, 5'(m_q_f.size())};
                n_vec++;
                if ({bs.full_o, bs.afull_o, bs.empty_o, bs.aempty_o, bs.ovf_o, bs.udf_o, bs.cnt_o, bs.rd_data_o} !== exp_s) begin
                    n_err++; $display("FAIL random_std ph=%0d cyc=%0d got=%h exp=%h", ph, i,
                                      {bs.full_o, bs.afull_o, bs.empty_o, bs.aempty_o, bs.ovf_o, bs.udf_o, bs.cnt_o, bs.rd_data_o}, exp_s);
                end
                n_vec++;
                if ({bf.full_o, bf.afull_o, bf.empty_o, bf.aempty_o, bf.ovf_o, bf.udf_o, bf.cnt_o} !== exp_f) begin
                    n_err++; $display("FAIL random_fwft ph=%0d cyc=%0d got=%h exp=%h", ph, i,
                                      {bf.full_o, bf.afull_o, bf.empty_o, bf.aempty_o, bf.ovf_o, bf.udf_o, bf.cnt_o}, exp_f);
                end
                if (m_shown) begin
                    n_vec++;
                    if (bf.rd_data_o !== m_q_f[0]) begin
                        n_err++; $display("FAIL random_fwft_data ph=%0d cyc=%0d got=%h exp=%h", ph, i, bf.rd_data_o, m_q_f[0]);
                    end
                end
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        wr_en = 1'b1; rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin wr_data = 8'($urandom); tick(); end
        wr_en = 1'b1; rd_en = 1'b0; tick();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bs.full_o, bs.afull_o, bs.empty_o, bs.aempty_o, bs.ovf_o, bs.udf_o, bs.cnt_o, bs.rd_data_o} !== {6'b001100, 5'd0, 8'd0}) begin
            n_err++; $display("FAIL async_reset_std got=%h exp=%h",
                              {bs.full_o, bs.afull_o, bs.empty_o, bs.aempty_o, bs.ovf_o, bs.udf_o, bs.cnt_o, bs.rd_data_o}, {6'b001100, 5'd0, 8'd0});
        end
        n_vec++;
        if ({bf.full_o, bf.afull_o, bf.empty_o, bf.aempty_o, bf.ovf_o, bf.udf_o, bf.cnt_o, bf.rd_data_o} !== {6'b001100, 5'd0, 8'd0}) begin
            n_err++; $display("FAIL async_reset_fwft got=%h exp=%h",
                              {bf.full_o, bf.afull_o, bf.empty_o, bf.aempty_o, bf.ovf_o, bf.udf_o, bf.cnt_o, bf.rd_data_o}, {6'b001100, 5'd0, 8'd0});
        end
        idle(); tick(); rst_n = 1'b1; tick();
    endtask

    initial begin
        #2;
        test_reset();
        test_fill();
        test_drain();
        test_fwft_single();
        test_full_rw();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
